// File: rtl/raster_scan_ctrl.sv
// Raster scan sequencer: walks a triangle's bounding box one pixel per cycle through an
// external edge-function tester and emits covered pixels as fragments.
module raster_scan_ctrl #(
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [COORD_WIDTH-1:0]       cmd_xmin,
    input  logic [COORD_WIDTH-1:0]       cmd_xmax,
    input  logic [COORD_WIDTH-1:0]       cmd_ymin,
    input  logic [COORD_WIDTH-1:0]       cmd_ymax,
    input  logic [6*COORD_WIDTH-1:0]     cmd_coefs,
    input  logic [6*COORD_WIDTH-1:0]     cmd_const,
    input  logic [COLOR_WIDTH-1:0]       cmd_color,
    output logic [COORD_WIDTH-1:0]       ppu_x,
    output logic [COORD_WIDTH-1:0]       ppu_y,
    output logic [6*COORD_WIDTH-1:0]     ppu_coefs,
    output logic [6*COORD_WIDTH-1:0]     ppu_const,
    output logic [COLOR_WIDTH-1:0]       ppu_color,
    input  logic                         ppu_valid,
    input  logic [COLOR_WIDTH-1:0]       ppu_color_out,
    output logic                         frag_valid,
    input  logic                         frag_ready,
    output logic [COORD_WIDTH-1:0]       frag_x,
    output logic [COORD_WIDTH-1:0]       frag_y,
    output logic [COLOR_WIDTH-1:0]       frag_color,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [COORD_WIDTH-1:0] ONE = {{(COORD_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state_q, state_d;
    logic [COORD_WIDTH-1:0]     x_q, x_d, y_q, y_d;
    logic [COORD_WIDTH-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [6*COORD_WIDTH-1:0]   coefs_q, coefs_d, const_q, const_d;
    logic [COLOR_WIDTH-1:0]     color_q, color_d;
    logic                       fv_q, fv_d;
    logic [COORD_WIDTH-1:0]     fx_q, fx_d, fy_q, fy_d;
    logic [COLOR_WIDTH-1:0]     fc_q, fc_d;
    logic                       done_q, done_d;
    logic                       adv_s;
    logic                       empty_s;

    assign adv_s   = !fv_q || frag_ready;
    assign empty_s = ($signed(cmd_xmin) > $signed(cmd_xmax)) ||
                     ($signed(cmd_ymin) > $signed(cmd_ymax));

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign ppu_x      = x_q;
    assign ppu_y      = y_q;
    assign ppu_coefs  = coefs_q;
    assign ppu_const  = const_q;
    assign ppu_color  = color_q;
    assign frag_valid = fv_q;
    assign frag_x     = fx_q;
    assign frag_y     = fy_q;
    assign frag_color = fc_q;

    // Next-state logic: command latch, scan stepping and fragment register control.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        coefs_d = coefs_q;
        const_d = const_q;
        color_d = color_q;
        fv_d    = fv_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        fc_d    = fc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    xmin_d  = cmd_xmin;
                    xmax_d  = cmd_xmax;
                    ymax_d  = cmd_ymax;
                    coefs_d = cmd_coefs;
                    const_d = cmd_const;
                    color_d = cmd_color;
                    x_d     = cmd_xmin;
                    y_d     = cmd_ymin;
                    if (empty_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (adv_s) begin
                    if (ppu_valid) begin
                        fv_d = 1'b1;
                        fx_d = x_q;
                        fy_d = y_q;
                        fc_d = ppu_color_out;
                    end else begin
                        fv_d = 1'b0;
                    end
                    // Compare before incrementing so a box ending at the max signed value never wraps.
                    if (x_q == xmax_q) begin
                        x_d = xmin_q;
                        if (y_q == ymax_q) begin
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + ONE;
                        end
                    end else begin
                        x_d = x_q + ONE;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            DRAIN: begin
                if (adv_s) begin
                    fv_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                fv_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight triangle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= {COORD_WIDTH{1'b0}};
            y_q     <= {COORD_WIDTH{1'b0}};
            xmin_q  <= {COORD_WIDTH{1'b0}};
            xmax_q  <= {COORD_WIDTH{1'b0}};
            ymax_q  <= {COORD_WIDTH{1'b0}};
            coefs_q <= {(6*COORD_WIDTH){1'b0}};
            const_q <= {(6*COORD_WIDTH){1'b0}};
            color_q <= {COLOR_WIDTH{1'b0}};
            fv_q    <= 1'b0;
            fx_q    <= {COORD_WIDTH{1'b0}};
            fy_q    <= {COORD_WIDTH{1'b0}};
            fc_q    <= {COLOR_WIDTH{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            coefs_q <= coefs_d;
            const_q <= const_d;
            color_q <= color_d;
            fv_q    <= fv_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fc_q    <= fc_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl: directed triangles with hand-computed fragment lists.
module tb_raster_scan_ctrl;
    localparam int CW = 16;
    localparam int KW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [CW-1:0]   cmd_xmin = '0, cmd_xmax = '0, cmd_ymin = '0, cmd_ymax = '0;
    logic [6*CW-1:0] cmd_coefs = '0, cmd_const = '0;
    logic [KW-1:0]   cmd_color = '0;
    logic [CW-1:0]   ppu_x, ppu_y;
    logic [6*CW-1:0] ppu_coefs, ppu_const;
    logic [KW-1:0]   ppu_color;
    logic            ppu_valid;
    logic [KW-1:0]   ppu_color_out;
    logic            frag_valid;
    logic            frag_ready = 1'b1;
    logic [CW-1:0]   frag_x, frag_y;
    logic [KW-1:0]   frag_color;
    logic            busy, done;

    raster_scan_ctrl #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_xmin(cmd_xmin), .cmd_xmax(cmd_xmax), .cmd_ymin(cmd_ymin), .cmd_ymax(cmd_ymax),
        .cmd_coefs(cmd_coefs), .cmd_const(cmd_const), .cmd_color(cmd_color),
        .ppu_x(ppu_x), .ppu_y(ppu_y), .ppu_coefs(ppu_coefs), .ppu_const(ppu_const),
        .ppu_color(ppu_color), .ppu_valid(ppu_valid), .ppu_color_out(ppu_color_out),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_color(frag_color), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [KW-1:0] c;
        int            rel;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, acc_cyc = 0;
    int   exp_done_rel = -1;
    int   done_seen = 0;
    bit   ppu_real = 1'b0;
    bit   rand_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [CW-1:0] sx, sy;
    logic [KW-1:0] sc;

    // Edge-function model of the external ppu: covered when all three edges are >= 0.
    always_comb begin
        longint e;
        ppu_valid     = 1'b1;
        ppu_color_out = ppu_color;
        if (ppu_real) begin
            for (int i = 0; i < 3; i++) begin
                e = longint'($signed(ppu_coefs[(2*i)*CW +: CW])) * longint'($signed(ppu_x))
                  + longint'($signed(ppu_coefs[(2*i+1)*CW +: CW])) * longint'($signed(ppu_y))
                  + longint'($signed(ppu_const[i*2*CW +: 2*CW]));
                if (e < 0) ppu_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            frag_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every fragment handshake and watches done / stall stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && frag_valid) begin
                    check("stall_hold", {frag_x, frag_y, frag_color}, {sx, sy, sc});
                end
                if (frag_valid && frag_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frag", {frag_x, frag_y}, 0);
                        if ({frag_x, frag_y} == 0) begin
                            n_err++;
                            $display("FAIL unexpected_frag: got (0,0) expected none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("frag_xyc", {frag_x, frag_y, frag_color}, {e.x, e.y, e.c});
                        if (e.rel >= 0) check("frag_cycle", cyc - acc_cyc, e.rel);
                    end
                end
                if (done) begin
                    done_seen++;
                    if (exp_done_rel != -1) check("done_cycle", cyc - acc_cyc, exp_done_rel);
                end
                stall_prev = frag_valid && !frag_ready;
                sx = frag_x; sy = frag_y; sc = frag_color;
            end
        end
    end

    task automatic push(input int x, input int y, input int c, input int rel);
        exp_t e;
        e.x = CW'(x); e.y = CW'(y); e.c = KW'(c); e.rel = rel;
        exp_q.push_back(e);
    endtask

    task automatic send(input int x0, input int x1, input int y0, input int y1, input int c);
        int budget = 0;
        while (!cmd_ready && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        if (!cmd_ready) begin
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
            $fatal(1);
        end
        cmd_xmin = CW'(x0); cmd_xmax = CW'(x1);
        cmd_ymin = CW'(y0); cmd_ymax = CW'(y1);
        cmd_color = KW'(c);
        cmd_valid = 1'b1;
        acc_cyc = cyc;
        done_seen = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_xmin = 16'h5555; cmd_color = 16'hDEAD;
    endtask

    task automatic finish_tri(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_seen > 0 && exp_q.size() == 0) break;
        end
        check({name, "_done_count"}, done_seen, 1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
        #1;
    endtask

    task automatic push_tri2;
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) push(x, y, 16'h0F0F, -1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outs", {busy, done, frag_valid, frag_x, frag_y, ppu_x, ppu_y}, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Test 1: 4x4 box, always covered, no backpressure, exact timing
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) push(x, y, 16'hA5A5, 2 + y*4 + x);
        exp_done_rel = 18;
        send(0, 3, 0, 3, 16'hA5A5);
        for (int r = 1; r <= 18; r++) begin
            @(negedge clk);
            check("t1_busy", busy, (r <= 17) ? 1 : 0);
        end
        finish_tri("t1", 50);

        // Test 2: real edge functions x>=0, y>=0, x+y<=4
        ppu_real = 1'b1;
        cmd_coefs = {16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0001};
        cmd_const = {32'd4, 32'd0, 32'd0};
        push_tri2();
        exp_done_rel = 27;
        send(0, 4, 0, 4, 16'h0F0F);
        cmd_coefs = '0; cmd_const = '0;
        finish_tri("t2", 80);

        // Test 3: same triangle with random backpressure
        cmd_coefs = {16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0001};
        cmd_const = {32'd4, 32'd0, 32'd0};
        rand_ready = 1'b1;
        push_tri2();
        exp_done_rel = -1;
        send(0, 4, 0, 4, 16'h0F0F);
        finish_tri("t3", 400);
        rand_ready = 1'b0;
        ppu_real = 1'b0;
        @(posedge clk); #1;

        // Test 4: empty box
        exp_done_rel = 2;
        send(5, 2, 0, 3, 16'h1111);
        @(negedge clk);
        check("t4_ready_c1", cmd_ready, 0);
        @(negedge clk);
        check("t4_ready_c2", cmd_ready, 1);
        finish_tri("t4", 10);

        // Test 5: single column at the max signed x
        push(16'h7FFF, 0, 16'h2222, 2);
        push(16'h7FFF, 1, 16'h2222, 3);
        push(16'h7FFF, 2, 16'h2222, 4);
        exp_done_rel = 5;
        send(16'h7FFF, 16'h7FFF, 0, 2, 16'h2222);
        finish_tri("t5", 20);

        // Test 6: reset mid-scan, then a fresh triangle
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) push(x, y, 16'hA5A5, 2 + y*4 + x);
        exp_done_rel = -100;
        send(0, 3, 0, 3, 16'hA5A5);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_ready", cmd_ready, 1);
        check("t6_rst_outs", {busy, done, frag_valid, frag_x, frag_y, ppu_x, ppu_y}, 0);
        check("t6_partial", exp_q.size(), 10);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        check("t6_no_done", done_seen, 0);
        push(2, 1, 16'h3333, 2);
        push(3, 1, 16'h3333, 3);
        push(2, 2, 16'h3333, 4);
        push(3, 2, 16'h3333, 5);
        exp_done_rel = 6;
        send(2, 3, 1, 2, 16'h3333);
        finish_tri("t6", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
